// File: rtl/cmd_arbiter_rr_n_if.sv
// Command arbiter bus: per-channel request lines in, one registered winner out.
// Latency: n/a (signal bundle only).
// Backpressure: req_ready is the per-channel accept; the output side has none.
interface cmd_arbiter_rr_n_if #(
    parameter int NUM_REQUESTS = 4,
    parameter int CMD_W        = 128
);
    localparam int CHAN_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;

    logic [NUM_REQUESTS-1:0]       req_valid;
    logic [NUM_REQUESTS*CMD_W-1:0] req_line;
    logic [NUM_REQUESTS-1:0]       req_ready;
    logic                          out_valid;
    logic [CMD_W-1:0]              out_line;
    logic [CHAN_W-1:0]             out_chan;

    // Command sources plus the consumer of the registered winner.
    modport master (
        output req_valid, req_line,
        input  req_ready, out_valid, out_line, out_chan
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_line,
        output req_ready, out_valid, out_line, out_chan
    );
endinterface

// File: rtl/cmd_arbiter_rr_n.sv
// N-way command arbiter, fixed or round-robin priority, gated by downstream credits.
// Latency: winner appears on out_* one cycle after its combinational grant.
// Backpressure: no grant while disabled or out of credits; sources hold lines until req_ready.
module cmd_arbiter_rr_n #(
    parameter int NUM_REQUESTS = 4,
    parameter int CMD_W        = 128,
    parameter int INIT_CREDITS = 64,
    parameter int CREDIT_W     = 8
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic                 enabled,
    input  logic                 mode_rr,
    input  logic                 credit_return,
    cmd_arbiter_rr_n_if.slave    bus,
    output logic [CREDIT_W-1:0]  credits,
    output logic                 credit_overflow
);
    localparam int CHAN_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
    localparam logic [CREDIT_W-1:0] CRED_INIT = CREDIT_W'(INIT_CREDITS);

    logic [CHAN_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    logic [CMD_W-1:0]        out_line_q, out_line_d;
    logic [CHAN_W-1:0]       out_chan_q, out_chan_d;
    logic [CREDIT_W-1:0]     credits_q, credits_d;
    logic                    overflow_q, overflow_d;

    logic                    grant_found;
    logic [CHAN_W-1:0]       grant_idx;
    logic [CHAN_W-1:0]       cand;
    logic                    can_grant;
    logic [NUM_REQUESTS-1:0] ready;
    logic                    xfer;

    // Channel index (base + step) wrapped into 0..NUM_REQUESTS-1.
    function automatic logic [CHAN_W-1:0] wrap_idx(input logic [CHAN_W-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NUM_REQUESTS) s = s - NUM_REQUESTS;
        return CHAN_W'(s);
    endfunction

    // Find the winner: scan upward from rr_ptr in round-robin mode, from 0 in fixed mode.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQUESTS; k++) begin
            cand = wrap_idx(mode_rr ? rr_ptr_q : '0, k);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot accept; rstn gates it so nothing is accepted while reset is held.
    always_comb begin
        can_grant = rstn & enabled & (credits_q != '0);
        ready     = '0;
        if (can_grant && grant_found) ready[grant_idx] = 1'b1;
        xfer      = |(ready & bus.req_valid);
    end

    // Next-state: register the winner, advance the pointer, track credits.
    always_comb begin
        out_valid_d = xfer;
        out_line_d  = xfer ? bus.req_line[grant_idx*CMD_W +: CMD_W] : '0;
        out_chan_d  = xfer ? grant_idx : '0;
        rr_ptr_d    = xfer ? wrap_idx(grant_idx, 1) : rr_ptr_q;
        credits_d   = credits_q;
        overflow_d  = overflow_q;
        case ({xfer, credit_return})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: begin
                // A return with every credit already home is bogus: drop it and flag.
                if (credits_q == CRED_INIT) overflow_d = 1'b1;
                else                        credits_d  = credits_q + 1'b1;
            end
            default: credits_d = credits_q;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_line_q  <= '0;
            out_chan_q  <= '0;
            credits_q   <= CRED_INIT;
            overflow_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_line_q  <= out_line_d;
            out_chan_q  <= out_chan_d;
            credits_q   <= credits_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_line     = out_line_q;
    assign bus.out_chan     = out_chan_q;
    assign credits          = credits_q;
    assign credit_overflow  = overflow_q;
endmodule

// File: tb/tb_cmd_arbiter_rr_n.sv
// Directed bench for cmd_arbiter_rr_n: two instances, INIT_CREDITS=8 and INIT_CREDITS=2.
// Latency: checks registered outputs one cycle after each grant.
// Backpressure: credit exhaustion and enable gating exercised explicitly.
module tb_cmd_arbiter_rr_n;
    logic clock = 1'b0;
    logic rstn, enabled, mode_rr, credit_return, en2, ret2;
    logic [7:0] credits, credits2;
    logic ovf, ovf2;
    int total, bad;

    cmd_arbiter_rr_n_if #(.NUM_REQUESTS(4), .CMD_W(128)) bus ();
    cmd_arbiter_rr_n_if #(.NUM_REQUESTS(4), .CMD_W(128)) bus2 ();

    cmd_arbiter_rr_n #(.NUM_REQUESTS(4), .CMD_W(128), .INIT_CREDITS(8), .CREDIT_W(8)) dut (
        .clock(clock), .rstn(rstn), .enabled(enabled), .mode_rr(mode_rr),
        .credit_return(credit_return), .bus(bus), .credits(credits), .credit_overflow(ovf));

    cmd_arbiter_rr_n #(.NUM_REQUESTS(4), .CMD_W(128), .INIT_CREDITS(2), .CREDIT_W(8)) dut2 (
        .clock(clock), .rstn(rstn), .enabled(en2), .mode_rr(mode_rr),
        .credit_return(ret2), .bus(bus2), .credits(credits2), .credit_overflow(ovf2));

    always #5 clock = ~clock;

    function automatic logic [127:0] line_of(input int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 | 32'(i + 1);
        return {w, ~w, w ^ 32'h0F0F_0F0F, w};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        #12;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_line !== 128'd0) begin bad++; $display("FAIL rst_out_line got=%h exp=0", bus.out_line); end
        total++; if (bus.out_chan !== 2'd0) begin bad++; $display("FAIL rst_out_chan got=%0d exp=0", bus.out_chan); end
        total++; if (credits !== 8'd8) begin bad++; $display("FAIL rst_credits got=%0d exp=8", credits); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", ovf); end
        total++; if (credits2 !== 8'd2) begin bad++; $display("FAIL rst_credits2 got=%0d exp=2", credits2); end
        bus.req_valid = 4'b0000;
        @(negedge clock);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_credit_exhaust;
        mode_rr = 1'b0; en2 = 1'b1; ret2 = 1'b0; bus2.req_valid = 4'b0001;
        for (int n = 0; n < 2; n++) begin
            #1;
            total++; if (bus2.req_ready !== 4'b0001) begin bad++; $display("FAIL cr_ready%0d got=%b exp=0001", n, bus2.req_ready); end
            tick();
            total++; if (bus2.out_valid !== 1'b1) begin bad++; $display("FAIL cr_valid%0d got=%b exp=1", n, bus2.out_valid); end
            total++; if (credits2 !== 8'(1 - n)) begin bad++; $display("FAIL cr_credits%0d got=%0d exp=%0d", n, credits2, 1 - n); end
        end
        #1;
        total++; if (bus2.req_ready !== 4'b0000) begin bad++; $display("FAIL cr_empty_ready got=%b exp=0000", bus2.req_ready); end
        tick();
        total++; if (bus2.out_valid !== 1'b0) begin bad++; $display("FAIL cr_empty_valid got=%b exp=0", bus2.out_valid); end
        ret2 = 1'b1;
        #1;
        total++; if (bus2.req_ready !== 4'b0000) begin bad++; $display("FAIL cr_ret_ready got=%b exp=0000", bus2.req_ready); end
        tick();
        ret2 = 1'b0;
        total++; if (credits2 !== 8'd1) begin bad++; $display("FAIL cr_ret_credits got=%0d exp=1", credits2); end
        total++; if (bus2.out_valid !== 1'b0) begin bad++; $display("FAIL cr_ret_valid got=%b exp=0", bus2.out_valid); end
        #1;
        total++; if (bus2.req_ready !== 4'b0001) begin bad++; $display("FAIL cr_again_ready got=%b exp=0001", bus2.req_ready); end
        tick();
        total++; if (bus2.out_valid !== 1'b1) begin bad++; $display("FAIL cr_again_valid got=%b exp=1", bus2.out_valid); end
        total++; if (credits2 !== 8'd0) begin bad++; $display("FAIL cr_again_credits got=%0d exp=0", credits2); end
        #1;
        total++; if (bus2.req_ready !== 4'b0000) begin bad++; $display("FAIL cr_final_ready got=%b exp=0000", bus2.req_ready); end
        en2 = 1'b0; bus2.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_fixed;
        mode_rr = 1'b0; enabled = 1'b1; bus.req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL fix_ready%0d got=%b exp=0001", c, bus.req_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd0) begin bad++; $display("FAIL fix_out%0d got=%b/%0d exp=1/0", c, bus.out_valid, bus.out_chan); end
            total++; if (bus.out_line !== line_of(0)) begin bad++; $display("FAIL fix_line%0d got=%h exp=%h", c, bus.out_line, line_of(0)); end
        end
        total++; if (credits !== 8'd5) begin bad++; $display("FAIL fix_credits got=%0d exp=5", credits); end
    endtask

    task automatic test_simul_return;
        bus.req_valid = 4'b0001; credit_return = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL sim_ready got=%b exp=0001", bus.req_ready); end
        tick();
        credit_return = 1'b0; bus.req_valid = 4'b0000;
        total++; if (credits !== 8'd5) begin bad++; $display("FAIL sim_credits got=%0d exp=5", credits); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sim_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_round_robin;
        int exp_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        rstn = 1'b0; #1; rstn = 1'b1; #1;
        total++; if (credits !== 8'd8) begin bad++; $display("FAIL rr_reset_credits got=%0d exp=8", credits); end
        mode_rr = 1'b1; bus.req_valid = 4'b1111; credit_return = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (bus.req_ready !== 4'(1 << exp_ch[i])) begin bad++; $display("FAIL rr_ready%0d got=%b exp=%b", i, bus.req_ready, 4'(1 << exp_ch[i])); end
            tick();
            total++; if (bus.out_chan !== 2'(exp_ch[i]) || bus.out_line !== line_of(exp_ch[i])) begin bad++; $display("FAIL rr_out%0d got=%0d exp=%0d", i, bus.out_chan, exp_ch[i]); end
        end
        total++; if (credits !== 8'd8) begin bad++; $display("FAIL rr_credits got=%0d exp=8", credits); end
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b1001;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL rr_1001_first got=%b exp=1000", bus.req_ready); end
        tick();
        total++; if (bus.out_chan !== 2'd3) begin bad++; $display("FAIL rr_1001_chan3 got=%0d exp=3", bus.out_chan); end
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rr_1001_second got=%b exp=0001", bus.req_ready); end
        tick();
        total++; if (bus.out_chan !== 2'd0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_1001_chan0 got=%0d exp=0", bus.out_chan); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rr_overflow got=%b exp=0", ovf); end
    endtask

    task automatic test_mode_switch;
        mode_rr = 1'b0; bus.req_valid = 4'b0101;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL ms_fixed got=%b exp=0001", bus.req_ready); end
        tick();
        mode_rr = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL ms_rr got=%b exp=0100", bus.req_ready); end
        tick();
        total++; if (bus.out_chan !== 2'd2) begin bad++; $display("FAIL ms_chan got=%0d exp=2", bus.out_chan); end
        credit_return = 1'b0; bus.req_valid = 4'b0000;
    endtask

    task automatic test_disable;
        enabled = 1'b0; bus.req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL dis_ready%0d got=%b exp=0000", c, bus.req_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b0 || bus.out_line !== 128'd0 || bus.out_chan !== 2'd0) begin bad++; $display("FAIL dis_out%0d got=%b exp=0", c, bus.out_valid); end
        end
        total++; if (credits !== 8'd8) begin bad++; $display("FAIL dis_credits got=%0d exp=8", credits); end
        enabled = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL dis_ptr_held got=%b exp=1000", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        total++; if (bus.out_chan !== 2'd3 || credits !== 8'd7) begin bad++; $display("FAIL dis_resume got=%0d/%0d exp=3/7", bus.out_chan, credits); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.out_line !== 128'd0 || bus.out_chan !== 2'd0) begin bad++; $display("FAIL idle_out got=%b/%h exp=0/0", bus.out_valid, bus.out_line); end
    endtask

    task automatic test_overflow;
        credit_return = 1'b1; tick(); credit_return = 1'b0;
        total++; if (credits !== 8'd8 || ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill got=%0d/%b exp=8/0", credits, ovf); end
        credit_return = 1'b1; tick(); credit_return = 1'b0;
        total++; if (credits !== 8'd8 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d/%b exp=8/1", credits, ovf); end
        tick(); tick();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_reset_mid;
        mode_rr = 1'b1; bus.req_valid = 4'b1111;
        tick();
        total++; if (bus.out_valid !== 1'b1 || credits !== 8'd7) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=1/7", bus.out_valid, credits); end
        rstn = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.out_line !== 128'd0) begin bad++; $display("FAIL mid_clear got=%b exp=0", bus.out_valid); end
        total++; if (credits !== 8'd8 || ovf !== 1'b0) begin bad++; $display("FAIL mid_credits got=%0d/%b exp=8/0", credits, ovf); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_in_rst got=%b exp=0000", bus.req_ready); end
        #2; rstn = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr0 got=%b exp=0001", bus.req_ready); end
        tick();
        total++; if (bus.out_chan !== 2'd0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_first got=%0d exp=0", bus.out_chan); end
        bus.req_valid = 4'b0000;
    endtask

    initial begin
        total = 0; bad = 0;
        rstn = 1'b0; enabled = 1'b1; mode_rr = 1'b0; credit_return = 1'b0;
        en2 = 1'b0; ret2 = 1'b0;
        bus.req_valid = 4'b1111; bus2.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.req_line[i*128 +: 128]  = line_of(i);
            bus2.req_line[i*128 +: 128] = line_of(i);
        end
        #3;
        test_reset();
        test_credit_exhaust();
        test_fixed();
        test_simul_return();
        test_round_robin();
        test_mode_switch();
        test_disable();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
